// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray counter family.
// The helpers work at full 32-bit width. Narrower callers zero-extend the
// argument and truncate the result. Zero upper bits do not affect the
// low-order bits of either conversion.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB down.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] g
  );
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg

// File: rtl/gray_step_checker.sv
// Gray step checker. It watches successive counter gray values and raises a
// sticky error when a count step moves the gray value by a Hamming distance
// other than one. Updates caused by a load or a reset are exempt, because
// the step strobe is low on those cycles. Only the rst input clears the
// error.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_step_err
);

  localparam int CNT_W = $clog2(GRAY_MAX_WIDTH + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  logic [WIDTH-1:0] r_prev_gray;
  logic             r_last_step;
  logic             r_step_err;
  logic [CNT_W-1:0] w_dist;
  logic             w_bad_step;

  // Distance between the gray value before the last edge and the gray value after it.
  assign w_dist     = popcount(i_gray ^ r_prev_gray);
  assign w_bad_step = r_last_step && (w_dist != CNT_W'(1));

  // Track the previous gray value and the step strobe, and latch violations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_gray <= '0;
      r_last_step <= 1'b0;
      r_step_err  <= 1'b0;
    end else begin
      r_prev_gray <= i_gray;
      r_last_step <= i_step;
      if (w_bad_step) begin
        r_step_err <= 1'b1;
      end
    end
  end

  assign o_step_err = r_step_err;

endmodule : gray_step_checker

// File: rtl/gray_counter.sv
// Registered up/down counter with a Gray-coded primary output.
// It supports enable, a direction input, a Gray-coded parallel load and a
// one-cycle wrap pulse. The binary count is exported alongside the Gray
// count. Every output comes straight from a register.
// Optional build macro: GRAY_COUNTER_STEP_CHECK_EN. When it is defined, the
// design instantiates gray_step_checker to drive step_err. Otherwise
// step_err is tied low.
module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             wrap,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY =
    WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_VAL)));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  dir_e             w_dir;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_load_bin;
  logic             w_step_err;

  assign w_dir      = dir_e'(up);
  assign w_load_bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(load_gray)));

  // Next count value and wrap detection for a count step in the sampled direction.
  always_comb begin
    // NOTE: assigning defaults first means every path drives every output, so no latch is inferred.
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (w_dir == DIR_UP) begin
      w_bin_next  = r_bin + ONE;
      w_wrap_next = &r_bin;
    end else begin
      w_bin_next  = r_bin - ONE;
      w_wrap_next = ~|r_bin;
    end
  end

  assign w_gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_bin_next)));

  // Counter state update. The priority order is reset, load, count, hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register here see the pre-edge values.
    if (rst) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_bin  <= w_load_bin;
      r_gray <= load_gray;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end else begin
      r_wrap <= 1'b0;
    end
  end

`ifdef GRAY_COUNTER_STEP_CHECK_EN
  logic w_count_step;

  // A count step is an enabled update that is neither a load nor a reset.
  assign w_count_step = en && !load && !rst;

  gray_step_checker #(
    .WIDTH(WIDTH)
  ) u_step_checker (
    .clk       (clk),
    .rst       (rst),
    .i_step    (w_count_step),
    .i_gray    (r_gray),
    .o_step_err(w_step_err)
  );
`else
  assign w_step_err = 1'b0;
`endif

  assign gray     = r_gray;
  assign binary   = r_bin;
  assign wrap     = r_wrap;
  assign step_err = w_step_err;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH=4 and RST_VAL=0.
// Expected results are pushed to a scoreboard queue when stimulus is driven.
// They are popped and compared one clock edge later.
// When GRAY_COUNTER_STEP_CHECK_EN is defined, a WIDTH=8 instance also runs
// a full sweep and a bin-register corruption check.
module tb_gray_counter;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_gray = '0;
  logic [W-1:0] gray;
  logic [W-1:0] binary;
  logic         wrap;
  logic         step_err;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         sb[$];
  logic [W-1:0] m_bin  = '0;
  logic         m_wrap = 1'b0;

  always #5 clk = ~clk;

  gray_counter #(
    .WIDTH  (W),
    .RST_VAL(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_gray(load_gray),
    .gray     (gray),
    .binary   (binary),
    .wrap     (wrap),
    .step_err (step_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the parity of the gray bits at and above it.
  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Drive one cycle of stimulus, update the model, then compare after the edge.
  task automatic drive(input logic d_rst, input logic d_load, input logic [W-1:0] d_lg,
                       input logic d_en, input logic d_up);
    exp_t         x;
    logic [W-1:0] prev_gray;
    rst = d_rst; load = d_load; load_gray = d_lg; en = d_en; up = d_up;
    if (d_rst) begin
      m_bin = '0; m_wrap = 1'b0;
    end else if (d_load) begin
      m_bin = m_g2b(d_lg); m_wrap = 1'b0;
    end else if (d_en) begin
      m_wrap = d_up ? (m_bin == 4'hF) : (m_bin == 4'h0);
      m_bin  = d_up ? m_bin + 4'd1 : m_bin - 4'd1;
    end else begin
      m_wrap = 1'b0;
    end
    sb.push_back('{bin: m_bin, gray: m_b2g(m_bin), wrap: m_wrap});
    prev_gray = gray;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("binary", 32'(binary), 32'(x.bin));
      check("gray", 32'(gray), 32'(x.gray));
      check("wrap", 32'(wrap), 32'(x.wrap));
      check("step_err", 32'(step_err), 32'd0);
      if (!d_rst && !d_load)
        check("gray_dist", 32'($countones(gray ^ prev_gray)), d_en ? 32'd1 : 32'd0);
    end
  endtask

`ifdef GRAY_COUNTER_STEP_CHECK_EN
  logic       rst8 = 1'b1;
  logic       en8 = 1'b0;
  logic       up8 = 1'b0;
  logic       load8 = 1'b0;
  logic [7:0] load_gray8 = '0;
  logic [7:0] gray8;
  logic [7:0] binary8;
  logic       wrap8;
  logic       step_err8;
  logic [7:0] m8 = '0;

  gray_counter #(
    .WIDTH  (8),
    .RST_VAL(0)
  ) dut8 (
    .clk      (clk),
    .rst      (rst8),
    .en       (en8),
    .up       (up8),
    .load     (load8),
    .load_gray(load_gray8),
    .gray     (gray8),
    .binary   (binary8),
    .wrap     (wrap8),
    .step_err (step_err8)
  );

  task automatic drive8(input logic d_rst, input logic d_en, input logic d_up);
    rst8 = d_rst; en8 = d_en; up8 = d_up;
    if (d_rst) m8 = '0;
    else if (d_en) m8 = d_up ? m8 + 8'd1 : m8 - 8'd1;
    @(posedge clk);
    @(negedge clk);
  endtask
`endif

  localparam logic [3:0] GRAY_SEQ [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    @(negedge clk);
    // Reset state.
    drive(1, 0, 4'h0, 0, 0);
    drive(1, 0, 4'h0, 0, 0);
    check("rst_gray", 32'(gray), 32'h0);

    // Full up sweep against the literal Gray sequence.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 4'h0, 1, 1);
      check("up_seq", 32'(gray), 32'(GRAY_SEQ[i]));
    end
    check("up_wrap_last", 32'(wrap), 32'd1);

    // Down-count from 0 wraps to all-ones.
    drive(1, 0, 4'h0, 0, 0);
    drive(0, 0, 4'h0, 1, 0);
    check("dn_bin0", 32'(binary), 32'hF);
    check("dn_gray0", 32'(gray), 32'h8);
    check("dn_wrap0", 32'(wrap), 32'd1);
    drive(0, 0, 4'h0, 1, 0);
    check("dn_gray1", 32'(gray), 32'h9);
    check("dn_wrap1", 32'(wrap), 32'd0);

    // Load wins over en, and counting resumes afterwards.
    drive(0, 1, 4'b1101, 1, 1);
    check("ld_bin", 32'(binary), 32'h9);
    drive(0, 0, 4'h0, 1, 1);
    check("ld_next", 32'(binary), 32'hA);

    // Direction toggling every cycle starting from binary 5.
    drive(0, 1, 4'b0111, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 4'h0, 1, (i % 2) == 0);
      check("toggle", 32'(binary), (i % 2) == 0 ? 32'd6 : 32'd5);
    end

    // Reset beats load and en mid-sequence, then hold keeps outputs constant.
    drive(0, 1, 4'b0100, 0, 0);
    check("pre_rst_bin", 32'(binary), 32'h7);
    drive(1, 1, 4'b1111, 1, 1);
    check("mid_rst_bin", 32'(binary), 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 4'h0, 0, 1);

    // Random mix of every control input.
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef GRAY_COUNTER_STEP_CHECK_EN
    // 8-bit sweep up and down: no step error expected.
    drive8(1, 0, 0);
    drive8(1, 0, 0);
    for (int i = 0; i < 512; i++) begin
      drive8(0, 1, i < 256);
      check("sweep8_bin", 32'(binary8), 32'(m8));
      check("sweep8_err", 32'(step_err8), 32'd0);
    end
    // Corrupt bin register before a count edge; the error must latch.
    drive8(1, 0, 0);
    force dut8.r_bin = 8'h5A;
    #1;
    release dut8.r_bin;
    drive8(0, 1, 1);
    drive8(0, 0, 1);
    check("force_err_set", 32'(step_err8), 32'd1);
    for (int i = 0; i < 4; i++) drive8(0, 0, 1);
    check("force_err_hold", 32'(step_err8), 32'd1);
    drive8(1, 0, 0);
    check("force_err_clr", 32'(step_err8), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_gray_counter

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, registered up/down counter whose primary output is Gray-coded. Successor to the combinational binary-to-Gray converter.
- Adds direction control, enable, Gray-coded parallel load and a wrap pulse.
- Used as the pointer and sequence source for Gray-coded address and position generation elsewhere in the design.
- Binary count is also exported for local arithmetic.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- RST_VAL, 0, binary count value loaded on reset; must be < 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- load_gray  input  WIDTH  load value, Gray-coded
- gray  output  WIDTH  current count, Gray-coded, registered
- binary  output  WIDTH  current count, binary, registered
- wrap  output  1  one-cycle pulse on modular wrap
- step_err  output  1  Gray step violation flag (optional feature only; tied 0 otherwise)

Behaviour:
- State
  - bin_q: WIDTH-bit binary register.
  - gray_q: WIDTH-bit register, always equal to bin2gray(bin_q), where bin2gray(b) = b ^ (b >> 1).
  - wrap_q: 1-bit register.
  - All outputs are driven directly from registers; no combinational input-to-output path.
- Reset (rst high at clk edge)
  - bin_q = RST_VAL; gray_q = bin2gray(RST_VAL); wrap_q = 0; step_err = 0.
  - Reset overrides load and en in the same cycle.
- Priority per edge: rst > load > en > hold.
- Load (load = 1)
  - bin_q = gray2bin(load_gray), where gray2bin is the prefix XOR from the MSB down: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - gray_q = load_gray; wrap_q = 0.
  - en and up are ignored that cycle.
- Count (en = 1, load = 0)
  - up = 1: bin_q = bin_q + 1 modulo 2**WIDTH.
  - up = 0: bin_q = bin_q - 1 modulo 2**WIDTH.
  - gray_q updates in the same edge; latency from en to the new gray value is 1 cycle.
- Wrap
  - wrap_q = 1 for exactly one cycle after a step from all-ones to 0 (up), or from 0 to all-ones (down).
  - Otherwise wrap_q = 0, including during hold, load and reset.
- Hold (en = 0, load = 0): all registers keep their value; wrap_q = 0.
- Direction may change on any cycle. The step takes the up value sampled on that edge; there is no turnaround bubble.
- Gray property: between any two consecutive non-load, non-reset cycles, gray changes in exactly one bit when en = 1 and in zero bits when en = 0. This includes both wrap transitions.
- Reset mid-count: the count is abandoned and the next cycle shows RST_VAL. No pending wrap pulse survives reset.

Optional Feature:
- Macro: GRAY_COUNTER_STEP_CHECK_EN
- Defined:
  - A checker registers the previous gray_q and a "last update was a count step" flag.
  - step_err is a sticky flag. It is set on the cycle after any count step whose Hamming distance from the previous gray value is not 1.
  - Steps following a load or reset are exempt.
  - step_err clears only on rst.
- Undefined:
  - The checker logic is absent and step_err is tied to 0.
  - The port list is unchanged in both builds.

Decomposition:
- Package gray_pkg holds:
  - function bin2gray(logic [31:0]) and function gray2bin(logic [31:0]), both width-generic via slicing;
  - typedef enum logic {DIR_DOWN = 0, DIR_UP = 1} dir_e;
  - localparam int GRAY_MAX_WIDTH = 32.
- One sub-module: gray_step_checker, containing a popcount of the XOR of successive gray values and the sticky flag. It is instantiated only under GRAY_COUNTER_STEP_CHECK_EN.

Test Plan:
- WIDTH=4, RST_VAL=0; rst 2 cycles, then en=1, up=1 for 16 cycles:
  - gray follows 0000, 0001, 0011, 0010, 0110, ..., 1000, 0000;
  - wrap = 1 only on the cycle gray returns to 0000;
  - binary matches gray2bin(gray) on every cycle.
- Down-count from reset value 0 with en=1, up=0:
  - first step gives binary 1111, gray 1000, wrap = 1;
  - next step gives binary 1110, gray 1001, wrap = 0.
- load=1, load_gray=4'b1101 together with en=1:
  - next cycle binary = 1001, gray = 1101, wrap = 0;
  - count proceeds from there on the following cycle.
- Toggle up every cycle with en=1 starting at binary 5:
  - binary sequence is 6, 5, 6, 5;
  - gray changes exactly 1 bit per cycle; wrap is never set.
- rst asserted on the same edge as load and en, mid-sequence (binary 0111):
  - next cycle binary = RST_VAL, gray = bin2gray(RST_VAL), wrap = 0;
  - en held low afterwards keeps all outputs constant.
- With GRAY_COUNTER_STEP_CHECK_EN defined, run a full up-and-down sweep at WIDTH=8:
  - step_err stays 0 throughout;
  - a forced bin_q corruption in a count cycle (bench force) sets step_err, which holds until rst.
